amo_controller: RTL and testbench
=================================

Name: amo_controller

Overview:
- Sequencer for the A-extension path (LR_W, SC_W, AMO_W) between the execute stage and the data-memory port.
- Runs the read–modify–write sequence for AMO_W.
- Holds the single LR/SC reservation and decides SC success.
- Reports the rd result and misalignment back to the pipeline, which stalls on busy_o.

Parameters:
RSV_GRAN_LOG2, 2, log2 of reservation granule in bytes (2 = one 32-bit word; address bits [31:RSV_GRAN_LOG2] compared).

Ports:
clk  input  1  core clock
reset_n  input  1  asynchronous active-low reset
req_i  input  1  start request; sampled only in S_IDLE
is_lr_i  input  1  request is LR_W
is_sc_i  input  1  request is SC_W
amo_op_i  input  10  one-hot iTypeAtomic_e (AMONOP..AMOMAXU); valid when neither LR nor SC
addr_i  input  32  effective address (rs1)
wdata_i  input  32  rs2 operand
busy_o  output  1  high in every state except S_IDLE
done_o  output  1  one-cycle completion pulse
result_o  output  32  rd value, valid with done_o
misaligned_o  output  1  with done_o: STORE_AMO_ADDRESS_MISALIGNED
mem_req_o  output  1  memory request
mem_we_o  output  4  byte write enables (0 = read)
mem_addr_o  output  32  word address (addr[1:0] = 0)
mem_wdata_o  output  32  store data
mem_gnt_i  input  1  request accepted this cycle
mem_rvalid_i  input  1  read data valid
mem_rdata_i  input  32  read data
snoop_we_i  input  1  another master/path wrote memory this cycle
snoop_addr_i  input  32  address of that write
clear_rsv_i  input  1  trap/xRET: drop reservation

Behaviour:
- Reset: async on reset_n low. State = S_IDLE; reservation invalid; all outputs 0.
- Reset mid-operation: mem_req_o drops immediately and no write completes from the controller side.
- States and transitions:
  - S_IDLE: on req_i, latch addr, wdata, op, then select next state:
    - addr[1:0] != 0 → S_DONE, misaligned_o = 1, result 0, no memory access.
    - SC → S_STORE if reservation valid and granule matches; otherwise S_DONE with result 1. The reservation is cleared in both cases.
    - LR, or AMO with op != AMONOP → S_READ.
    - AMO with AMONOP → S_DONE, result 0, no memory access.
  - S_READ: mem_req_o = 1, we = 0. Stays until mem_gnt_i, then → S_WAIT.
  - S_WAIT: waits for mem_rvalid_i, then latches old = mem_rdata_i.
    - LR: set reservation (valid, addr[31:RSV_GRAN_LOG2]), result = old → S_DONE.
    - AMO: register new = f(old, wdata) → S_STORE.
  - S_STORE: mem_req_o = 1, we = 4'hF, wdata = new (AMO) or latched wdata (SC). Holds until mem_gnt_i, then → S_DONE. Result = old (AMO) or 0 (SC success).
  - S_DONE: done_o = 1 for exactly one cycle → S_IDLE.
- req_i while busy_o = 1 is ignored.
- mem_addr_o, mem_we_o and mem_wdata_o stay stable while mem_req_o = 1 and mem_gnt_i = 0.
- AMO function f(old, rs2), 32-bit, wrap mod 2^32:
  - SWAP: rs2
  - ADD: old + rs2
  - XOR / AND / OR: bitwise
  - MIN / MAX: signed comparison
  - MINU / MAXU: unsigned comparison
  - Equal operands return old.
- Reservation clear sources:
  - SC issue
  - clear_rsv_i
  - snoop_we_i with matching granule
  - AMO store to matching granule
  - reset
- If a clear source and the LR set occur in the same cycle, clear wins: the reservation ends invalid.
- Latency with zero-wait memory (gnt same cycle, rvalid next cycle), done_o cycle counted from req_i acceptance edge = cycle 0:
  - AMO: 4
  - LR: 3
  - SC success: 2
  - SC fail / misaligned / AMONOP: 1
- Each extra gnt or rvalid wait cycle adds one cycle.

Test Plan:
- mem[0x100] = 5; AMOADD addr 0x100, rs2 = 3 → read 0x100, write 8 with we = 4'hF, result 5, done_o at cycle 4.
- mem[0x40] = 0xFFFFFFFE; AMOMIN rs2 = 1 → writes 0xFFFFFFFE; AMOMINU rs2 = 1 → writes 1; both return 0xFFFFFFFE.
- LR 0x200 (mem = 7) → result 7; then SC 0x200 rs2 = 9 → mem 9, result 0; second SC 0x200 → result 1, no mem_req_o.
- LR 0x300, then snoop_we_i at 0x302 → SC 0x300 fails (result 1). Repeat with snoop at 0x304 → SC succeeds.
- AMOSWAP addr 0x102 → done_o at cycle 1, misaligned_o = 1, mem_req_o never asserted.
- mem_gnt_i low for 3 cycles in S_READ; reset_n pulsed low in S_STORE → mem_req_o drops asynchronously, busy_o = 0, subsequent SC returns 1.

Source files
------------

// File: rtl/amo_controller.sv
// amo_controller: LR_W / SC_W / AMO_W sequencer between execute and the
// data-memory port; owns the single LR/SC reservation.
// Ports: clk, reset_n (async, active low); req_i/is_lr_i/is_sc_i/amo_op_i/
// addr_i/wdata_i request; busy_o/done_o/result_o/misaligned_o to pipeline;
// mem_* data-memory port; snoop_* foreign writes; clear_rsv_i trap/xRET.
module amo_controller #(
  parameter int RSV_GRAN_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_i,
  input  logic        is_lr_i,
  input  logic        is_sc_i,
  input  logic [9:0]  amo_op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        misaligned_o,
  output logic        mem_req_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        snoop_we_i,
  input  logic [31:0] snoop_addr_i,
  input  logic        clear_rsv_i
);

  localparam int G = RSV_GRAN_LOG2;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_STORE, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:2] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] result_q, result_d;
  logic [9:1]  op_q, op_d;
  logic        lr_q, lr_d;
  logic        sc_q, sc_d;
  logic        mis_q, mis_d;
  logic        rsv_valid_q, rsv_valid_d;
  logic [31:G] rsv_addr_q, rsv_addr_d;

  logic        lr_set;
  logic        clr;
  logic        sc_hit;
  logic        snoop_hit;
  logic [31:G] cmp_gran;
  logic        unused_snoop;

  assign unused_snoop = ^snoop_addr_i[G-1:0];

  // op bit 0 is AMONOP and never reaches the ALU
  function automatic logic [31:0] amo_f(
    input logic [9:1]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] r;
    r = a;
    unique case (1'b1)
      op[1]: r = b;
      op[2]: r = a + b;
      op[3]: r = a ^ b;
      op[4]: r = a & b;
      op[5]: r = a | b;
      op[6]: r = ($signed(a) <= $signed(b)) ? a : b;
      op[7]: r = ($signed(a) >= $signed(b)) ? a : b;
      op[8]: r = (a <= b) ? a : b;
      op[9]: r = (a >= b) ? a : b;
      default: r = a;
    endcase
    return r;
  endfunction

  // a clear arriving with the SC itself already kills the reservation
  assign sc_hit = rsv_valid_q
               && (rsv_addr_q == addr_i[31:G])
               && !clear_rsv_i
               && !(snoop_we_i && (snoop_addr_i[31:G] == addr_i[31:G]));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    result_d    = result_q;
    op_d        = op_q;
    lr_d        = lr_q;
    sc_d        = sc_q;
    mis_d       = mis_q;
    rsv_valid_d = rsv_valid_q;
    rsv_addr_d  = rsv_addr_q;
    lr_set      = 1'b0;
    clr         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_i) begin
          addr_d   = addr_i[31:2];
          data_d   = wdata_i;
          op_d     = amo_op_i[9:1];
          lr_d     = is_lr_i;
          sc_d     = is_sc_i;
          mis_d    = 1'b0;
          result_d = '0;
          if (addr_i[1:0] != 2'b00) begin
            mis_d   = 1'b1;
            state_d = S_DONE;
          end else if (is_sc_i) begin
            clr = 1'b1;
            if (sc_hit) begin
              state_d = S_STORE;
            end else begin
              result_d = 32'd1;
              state_d  = S_DONE;
            end
          end else if (is_lr_i || !amo_op_i[0]) begin
            state_d = S_READ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_READ: begin
        if (mem_gnt_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          result_d = mem_rdata_i;
          if (lr_q) begin
            lr_set  = 1'b1;
            state_d = S_DONE;
          end else begin
            data_d  = amo_f(op_q, mem_rdata_i, data_q);
            state_d = S_STORE;
          end
        end
      end
      S_STORE: begin
        if (mem_gnt_i) begin
          state_d = S_DONE;
          if (!sc_q && (addr_q[31:G] == rsv_addr_q)) clr = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // snoops are compared against the granule being reserved this cycle
    cmp_gran  = lr_set ? addr_q[31:G] : rsv_addr_q;
    snoop_hit = snoop_we_i && (snoop_addr_i[31:G] == cmp_gran);
    if (lr_set) rsv_addr_d = addr_q[31:G];
    if (clr || clear_rsv_i || snoop_hit) begin
      rsv_valid_d = 1'b0;
    end else if (lr_set) begin
      rsv_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      result_q    <= '0;
      op_q        <= '0;
      lr_q        <= 1'b0;
      sc_q        <= 1'b0;
      mis_q       <= 1'b0;
      rsv_valid_q <= 1'b0;
      rsv_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      result_q    <= result_d;
      op_q        <= op_d;
      lr_q        <= lr_d;
      sc_q        <= sc_d;
      mis_q       <= mis_d;
      rsv_valid_q <= rsv_valid_d;
      rsv_addr_q  <= rsv_addr_d;
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign result_o     = result_q;
  assign misaligned_o = done_o & mis_q;
  assign mem_req_o    = (state_q == S_READ) || (state_q == S_STORE);
  assign mem_we_o     = (state_q == S_STORE) ? 4'hF : 4'h0;
  assign mem_addr_o   = {addr_q, 2'b00};
  assign mem_wdata_o  = data_q;

endmodule

// File: tb/tb_amo_controller.sv
// tb_amo_controller: directed bench for amo_controller with a small
// word memory model on the data port.
module tb_amo_controller;

  localparam logic [9:0] OP_NOP  = 10'b00_0000_0001;
  localparam logic [9:0] OP_SWAP = 10'b00_0000_0010;
  localparam logic [9:0] OP_ADD  = 10'b00_0000_0100;
  localparam logic [9:0] OP_XOR  = 10'b00_0000_1000;
  localparam logic [9:0] OP_AND  = 10'b00_0001_0000;
  localparam logic [9:0] OP_OR   = 10'b00_0010_0000;
  localparam logic [9:0] OP_MIN  = 10'b00_0100_0000;
  localparam logic [9:0] OP_MAX  = 10'b00_1000_0000;
  localparam logic [9:0] OP_MINU = 10'b01_0000_0000;
  localparam logic [9:0] OP_MAXU = 10'b10_0000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_i, is_lr_i, is_sc_i;
  logic [9:0]  amo_op_i;
  logic [31:0] addr_i, wdata_i;
  logic        busy_o, done_o, misaligned_o;
  logic [31:0] result_o;
  logic        mem_req_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        snoop_we_i;
  logic [31:0] snoop_addr_i;
  logic        clear_rsv_i;

  logic [31:0] mem [0:1023];
  logic        gnt_en;
  logic        pre_we;
  logic [31:0] pre_addr, pre_data;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  int          req_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_addr = '0;
  logic [3:0]  last_we = '0;
  int          cyc = 0;
  int          acc = 0;

  int          n_vec = 0;
  int          n_err = 0;
  int          lat;
  logic [31:0] res;
  logic        mis;
  int          r0, w0;

  logic [9:0]  t_op  [7];
  logic [31:0] t_old [7];
  logic [31:0] t_rs  [7];
  logic [31:0] t_exp [7];

  always #5 clk = ~clk;

  assign mem_gnt_i    = mem_req_o & gnt_en;
  assign mem_rvalid_i = rvalid_q;
  assign mem_rdata_i  = rdata_q;

  amo_controller dut (
    .clk(clk),
    .reset_n(reset_n),
    .req_i(req_i),
    .is_lr_i(is_lr_i),
    .is_sc_i(is_sc_i),
    .amo_op_i(amo_op_i),
    .addr_i(addr_i),
    .wdata_i(wdata_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .result_o(result_o),
    .misaligned_o(misaligned_o),
    .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i),
    .snoop_we_i(snoop_we_i),
    .snoop_addr_i(snoop_addr_i),
    .clear_rsv_i(clear_rsv_i)
  );

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rvalid_q <= 1'b0;
    if (pre_we) mem[pre_addr[11:2]] <= pre_data;
    if (mem_req_o) req_cnt <= req_cnt + 1;
    if (mem_req_o && mem_gnt_i) begin
      if (mem_we_o != 4'h0) begin
        mem[mem_addr_o[11:2]] <= mem_wdata_o;
        wr_cnt    <= wr_cnt + 1;
        last_addr <= mem_addr_o;
        last_we   <= mem_we_o;
      end else begin
        rvalid_q <= 1'b1;
        rdata_q  <= mem[mem_addr_o[11:2]];
      end
    end
  end

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem[a[11:2]];
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic issue(input logic lr, input logic sc,
                       input logic [9:0] op, input logic [31:0] a,
                       input logic [31:0] d);
    @(posedge clk); #1;
    req_i = 1'b1; is_lr_i = lr; is_sc_i = sc;
    amo_op_i = op; addr_i = a; wdata_i = d;
    @(posedge clk); #1;
    acc = cyc;
    req_i = 1'b0;
  endtask

  task automatic wait_done(output int l, output logic [31:0] r,
                           output logic m);
    l = -1; r = '0; m = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done_o) begin
        l = cyc - acc + 1; r = result_o; m = misaligned_o;
        break;
      end
    end
    if (l < 0) begin
      n_vec++; n_err++;
      $display("FAIL done_timeout: no done_o within 60 cycles");
    end
  endtask

  task automatic snoop(input logic [31:0] a);
    @(posedge clk); #1;
    snoop_we_i = 1'b1; snoop_addr_i = a;
    @(posedge clk); #1;
    snoop_we_i = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy_o, done_o, mem_req_o, misaligned_o, mem_we_o} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_ctl: got %b want 00000000",
               {busy_o, done_o, mem_req_o, misaligned_o, mem_we_o});
    end
    n_vec++;
    if (result_o !== 32'h0) begin
      n_err++; $display("FAIL reset_result: got %h want 0", result_o);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_amo_add;
    preload(32'h100, 32'd5);
    w0 = wr_cnt;
    issue(1'b0, 1'b0, OP_ADD, 32'h100, 32'd3);
    wait_done(lat, res, mis);
    n_vec++;
    if (res !== 32'd5) begin
      n_err++; $display("FAIL add_result: got %h want 5", res);
    end
    n_vec++;
    if (lat !== 4) begin
      n_err++; $display("FAIL add_latency: got %0d want 4", lat);
    end
    n_vec++;
    if (rd(32'h100) !== 32'd8) begin
      n_err++; $display("FAIL add_mem: got %h want 8", rd(32'h100));
    end
    n_vec++;
    if ({last_we, last_addr, mis} !== {4'hF, 32'h100, 1'b0}) begin
      n_err++;
      $display("FAIL add_write: we %h addr %h mis %b want F 100 0",
               last_we, last_addr, mis);
    end
    n_vec++;
    if (wr_cnt - w0 !== 1) begin
      n_err++; $display("FAIL add_wrcnt: got %0d want 1", wr_cnt - w0);
    end
    @(negedge clk);
    n_vec++;
    if (done_o !== 1'b0) begin
      n_err++; $display("FAIL done_pulse: got %b want 0", done_o);
    end
  endtask

  task automatic test_minmax;
    preload(32'h40, 32'hFFFF_FFFE);
    issue(1'b0, 1'b0, OP_MIN, 32'h40, 32'd1);
    wait_done(lat, res, mis);
    n_vec++;
    if ({res, rd(32'h40)} !== {32'hFFFF_FFFE, 32'hFFFF_FFFE}) begin
      n_err++;
      $display("FAIL amomin: res %h mem %h want fffffffe fffffffe",
               res, rd(32'h40));
    end
    issue(1'b0, 1'b0, OP_MINU, 32'h40, 32'd1);
    wait_done(lat, res, mis);
    n_vec++;
    if ({res, rd(32'h40)} !== {32'hFFFF_FFFE, 32'h1}) begin
      n_err++;
      $display("FAIL amominu: res %h mem %h want fffffffe 00000001",
               res, rd(32'h40));
    end
  endtask

  task automatic test_ops;
    t_op[0] = OP_SWAP; t_old[0] = 32'h1111_1111;
    t_rs[0] = 32'h2222_2222; t_exp[0] = 32'h2222_2222;
    t_op[1] = OP_XOR; t_old[1] = 32'hF0F0_F0F0;
    t_rs[1] = 32'hFF00_FF00; t_exp[1] = 32'h0FF0_0FF0;
    t_op[2] = OP_AND; t_old[2] = 32'hF0F0_F0F0;
    t_rs[2] = 32'hFF00_FF00; t_exp[2] = 32'hF000_F000;
    t_op[3] = OP_OR; t_old[3] = 32'hF0F0_F0F0;
    t_rs[3] = 32'hFF00_FF00; t_exp[3] = 32'hFFF0_FFF0;
    t_op[4] = OP_MAX; t_old[4] = 32'h8000_0000;
    t_rs[4] = 32'd5; t_exp[4] = 32'd5;
    t_op[5] = OP_MAXU; t_old[5] = 32'h8000_0000;
    t_rs[5] = 32'd5; t_exp[5] = 32'h8000_0000;
    t_op[6] = OP_ADD; t_old[6] = 32'hFFFF_FFFF;
    t_rs[6] = 32'd2; t_exp[6] = 32'd1;
    for (int i = 0; i < 7; i++) begin
      preload(32'h80, t_old[i]);
      issue(1'b0, 1'b0, t_op[i], 32'h80, t_rs[i]);
      wait_done(lat, res, mis);
      n_vec++;
      if ({res, rd(32'h80)} !== {t_old[i], t_exp[i]}) begin
        n_err++;
        $display("FAIL op%0d: res %h mem %h want %h %h",
                 i, res, rd(32'h80), t_old[i], t_exp[i]);
      end
    end
  endtask

  task automatic test_lr_sc;
    preload(32'h200, 32'd7);
    issue(1'b1, 1'b0, 10'h0, 32'h200, 32'd0);
    wait_done(lat, res, mis);
    n_vec++;
    if ({res, lat} !== {32'd7, 32'd3}) begin
      n_err++; $display("FAIL lr: res %h lat %0d want 7 3", res, lat);
    end
    issue(1'b0, 1'b1, 10'h0, 32'h200, 32'd9);
    wait_done(lat, res, mis);
    n_vec++;
    if ({res, lat, rd(32'h200)} !== {32'd0, 32'd2, 32'd9}) begin
      n_err++;
      $display("FAIL sc_ok: res %h lat %0d mem %h want 0 2 9",
               res, lat, rd(32'h200));
    end
    r0 = req_cnt;
    issue(1'b0, 1'b1, 10'h0, 32'h200, 32'd4);
    wait_done(lat, res, mis);
    n_vec++;
    if ({res, lat, req_cnt - r0} !== {32'd1, 32'd1, 32'd0}) begin
      n_err++;
      $display("FAIL sc_again: res %h lat %0d reqs %0d want 1 1 0",
               res, lat, req_cnt - r0);
    end
  endtask

  task automatic test_snoop;
    preload(32'h300, 32'd0);
    issue(1'b1, 1'b0, 10'h0, 32'h300, 32'd0);
    wait_done(lat, res, mis);
    snoop(32'h302);
    issue(1'b0, 1'b1, 10'h0, 32'h300, 32'hAA);
    wait_done(lat, res, mis);
    n_vec++;
    if ({res, rd(32'h300)} !== {32'd1, 32'd0}) begin
      n_err++;
      $display("FAIL snoop_hit: res %h mem %h want 1 0", res, rd(32'h300));
    end
    issue(1'b1, 1'b0, 10'h0, 32'h300, 32'd0);
    wait_done(lat, res, mis);
    snoop(32'h304);
    issue(1'b0, 1'b1, 10'h0, 32'h300, 32'hAA);
    wait_done(lat, res, mis);
    n_vec++;
    if ({res, rd(32'h300)} !== {32'd0, 32'hAA}) begin
      n_err++;
      $display("FAIL snoop_miss: res %h mem %h want 0 aa", res, rd(32'h300));
    end
  endtask

  task automatic test_clear;
    issue(1'b1, 1'b0, 10'h0, 32'h200, 32'd0);
    wait_done(lat, res, mis);
    @(posedge clk); #1;
    clear_rsv_i = 1'b1;
    @(posedge clk); #1;
    clear_rsv_i = 1'b0;
    issue(1'b0, 1'b1, 10'h0, 32'h200, 32'd3);
    wait_done(lat, res, mis);
    n_vec++;
    if ({res, rd(32'h200)} !== {32'd1, 32'd9}) begin
      n_err++;
      $display("FAIL clear_rsv: res %h mem %h want 1 9", res, rd(32'h200));
    end
    issue(1'b1, 1'b0, 10'h0, 32'h200, 32'd0);
    wait_done(lat, res, mis);
    issue(1'b0, 1'b0, OP_ADD, 32'h200, 32'd1);
    wait_done(lat, res, mis);
    issue(1'b0, 1'b1, 10'h0, 32'h200, 32'd3);
    wait_done(lat, res, mis);
    n_vec++;
    if ({res, rd(32'h200)} !== {32'd1, 32'd10}) begin
      n_err++;
      $display("FAIL amo_clear: res %h mem %h want 1 a", res, rd(32'h200));
    end
  endtask

  task automatic test_misaligned;
    r0 = req_cnt;
    issue(1'b0, 1'b0, OP_SWAP, 32'h102, 32'h55);
    wait_done(lat, res, mis);
    n_vec++;
    if ({lat, mis, res, req_cnt - r0} !== {32'd1, 1'b1, 32'd0, 32'd0}) begin
      n_err++;
      $display("FAIL misaligned: lat %0d mis %b res %h reqs %0d want 1 1 0 0",
               lat, mis, res, req_cnt - r0);
    end
    issue(1'b0, 1'b0, OP_NOP, 32'h100, 32'h55);
    wait_done(lat, res, mis);
    n_vec++;
    if ({lat, mis, res, req_cnt - r0} !== {32'd1, 1'b0, 32'd0, 32'd0}) begin
      n_err++;
      $display("FAIL amonop: lat %0d mis %b res %h reqs %0d want 1 0 0 0",
               lat, mis, res, req_cnt - r0);
    end
  endtask

  task automatic test_back_to_back;
    preload(32'h100, 32'd20);
    preload(32'h140, 32'h55);
    w0 = wr_cnt;
    issue(1'b0, 1'b0, OP_ADD, 32'h100, 32'd1);
    req_i = 1'b1; is_lr_i = 1'b0; is_sc_i = 1'b0;
    amo_op_i = OP_SWAP; addr_i = 32'h140; wdata_i = 32'h66;
    @(posedge clk); #1;
    n_vec++;
    if (busy_o !== 1'b1) begin
      n_err++; $display("FAIL busy: got %b want 1", busy_o);
    end
    @(posedge clk); #1;
    req_i = 1'b0;
    wait_done(lat, res, mis);
    n_vec++;
    if ({res, lat, wr_cnt - w0} !== {32'd20, 32'd4, 32'd1}) begin
      n_err++;
      $display("FAIL busy_ignore: res %h lat %0d writes %0d want 14 4 1",
               res, lat, wr_cnt - w0);
    end
    n_vec++;
    if ({rd(32'h100), rd(32'h140)} !== {32'd21, 32'h55}) begin
      n_err++;
      $display("FAIL busy_mem: got %h %h want 15 55",
               rd(32'h100), rd(32'h140));
    end
  endtask

  task automatic test_stall_reset;
    preload(32'h500, 32'd10);
    gnt_en = 1'b0;
    issue(1'b0, 1'b0, OP_ADD, 32'h500, 32'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if ({mem_req_o, mem_we_o, mem_addr_o} !== {1'b1, 4'h0, 32'h500}) begin
        n_err++;
        $display("FAIL read_stall%0d: req %b we %h addr %h want 1 0 500",
                 i, mem_req_o, mem_we_o, mem_addr_o);
      end
    end
    @(posedge clk); #1;
    gnt_en = 1'b1;
    wait_done(lat, res, mis);
    n_vec++;
    if ({res, lat, rd(32'h500)} !== {32'd10, 32'd7, 32'd15}) begin
      n_err++;
      $display("FAIL stall_amo: res %h lat %0d mem %h want a 7 f",
               res, lat, rd(32'h500));
    end
    preload(32'h600, 32'h77);
    issue(1'b1, 1'b0, 10'h0, 32'h600, 32'd0);
    wait_done(lat, res, mis);
    gnt_en = 1'b0;
    w0 = wr_cnt;
    issue(1'b0, 1'b1, 10'h0, 32'h600, 32'h99);
    repeat (2) @(negedge clk);
    n_vec++;
    if ({mem_req_o, mem_we_o, mem_wdata_o} !== {1'b1, 4'hF, 32'h99}) begin
      n_err++;
      $display("FAIL store_hold: req %b we %h data %h want 1 f 99",
               mem_req_o, mem_we_o, mem_wdata_o);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({mem_req_o, busy_o} !== 2'b00) begin
      n_err++;
      $display("FAIL async_reset: req %b busy %b want 0 0", mem_req_o, busy_o);
    end
    gnt_en = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    n_vec++;
    if ({wr_cnt - w0, rd(32'h600)} !== {32'd0, 32'h77}) begin
      n_err++;
      $display("FAIL reset_nowrite: writes %0d mem %h want 0 77",
               wr_cnt - w0, rd(32'h600));
    end
    issue(1'b0, 1'b1, 10'h0, 32'h600, 32'h99);
    wait_done(lat, res, mis);
    n_vec++;
    if ({res, rd(32'h600)} !== {32'd1, 32'h77}) begin
      n_err++;
      $display("FAIL sc_after_reset: res %h mem %h want 1 77",
               res, rd(32'h600));
    end
  endtask

  initial begin
    req_i = 1'b0; is_lr_i = 1'b0; is_sc_i = 1'b0;
    amo_op_i = '0; addr_i = '0; wdata_i = '0;
    snoop_we_i = 1'b0; snoop_addr_i = '0; clear_rsv_i = 1'b0;
    gnt_en = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    test_reset();
    test_amo_add();
    test_minmax();
    test_ops();
    test_lr_sc();
    test_snoop();
    test_clear();
    test_misaligned();
    test_back_to_back();
    test_stall_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
